// File: rtl/bcd_cnt_pkg.sv
// bcd_cnt_pkg: shared BCD digit type, digit limit and helpers
// for the two-digit BCD modulo counter and its digit slice.
package bcd_cnt_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   function automatic logic bcd_valid(input bcd_digit_t digit);
      return digit <= BCD_MAX_DIGIT;
   endfunction

   // {tens, units} of a binary value 0..99; used for the
   // reset value and the terminal (MOD-1) constant.
   function automatic logic [7:0] bin_to_bcd2(input int value);
      logic [7:0] r;
      r[7:4] = 4'(value / 10);
      r[3:0] = 4'(value % 10);
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// bcd_digit: one BCD digit stepped up or down by a carry/borrow in.
// Ports: d_i current digit, cin step request, dn direction,
//        q_o next digit, cout carry (up 9->0) / borrow (down 0->9).
module bcd_digit
   import bcd_cnt_pkg::*;
(
   input  bcd_digit_t d_i,
   input  logic       cin,
   input  logic       dn,
   output bcd_digit_t q_o,
   output logic       cout
);

   always_comb begin
      q_o  = d_i;
      cout = 1'b0;
      if (cin) begin
         if (!dn) begin
            if (d_i >= BCD_MAX_DIGIT) begin
               q_o  = 4'd0;
               cout = 1'b1;
            end else begin
               q_o = d_i + 4'd1;
            end
         end else begin
            if (d_i == 4'd0) begin
               q_o  = BCD_MAX_DIGIT;
               cout = 1'b1;
            end else begin
               q_o = d_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo-MOD counter with preset,
// combinational terminal count co for same-clock cascading.
// Ports: clk, cr (sync reset to INIT), en, ld/ld_t/ld_u (checked
//        preset), bcd_t/bcd_u state, co carry, load_err reject pulse.
// Macro BCDCNT_DOWN_EN adds input dn (1 = count down).
module bcd_mod_counter
   import bcd_cnt_pkg::*;
#(
   parameter int MOD  = 24,
   parameter int INIT = 0
) (
   input  logic       clk,
   input  logic       cr,
   input  logic       en,
   input  logic       ld,
   input  logic [3:0] ld_u,
   input  logic [3:0] ld_t,
`ifdef BCDCNT_DOWN_EN
   input  logic       dn,
`endif
   output logic [3:0] bcd_u,
   output logic [3:0] bcd_t,
   output logic       co,
   output logic       load_err
);

   if (MOD < 2 || MOD > 100 || INIT < 0 || INIT >= MOD) begin : g_bad_param
      $fatal(1, "bcd_mod_counter: MOD must be 2..100 and INIT < MOD");
   end

   localparam logic [7:0] TOP_BCD  = bin_to_bcd2(MOD - 1);
   localparam logic [7:0] INIT_BCD = bin_to_bcd2(INIT);
   localparam logic [7:0] MOD_BIN  = 8'(MOD);

   bcd_digit_t u_q, u_d, u_nx;
   bcd_digit_t t_q, t_d, t_nx;
   logic       err_q, err_d;
   logic       u_cy, t_cy_unused;
   logic       dir;
   logic       term;
   logic       ld_ok;
   logic [7:0] ld_bin;

`ifdef BCDCNT_DOWN_EN
   assign dir = dn;
`else
   assign dir = 1'b0;
`endif

   bcd_digit u_units (
      .d_i  (u_q),
      .cin  (1'b1),
      .dn   (dir),
      .q_o  (u_nx),
      .cout (u_cy)
   );

   // Tens carry-out is never needed: the modulus wrap below
   // catches every case where the tens digit would overflow.
   bcd_digit u_tens (
      .d_i  (t_q),
      .cin  (u_cy),
      .dn   (dir),
      .q_o  (t_nx),
      .cout (t_cy_unused)
   );

   assign term = dir ? ({t_q, u_q} == 8'h00)
                     : ({t_q, u_q} == TOP_BCD);

   assign ld_bin = {4'd0, ld_t} * 8'd10 + {4'd0, ld_u};
   assign ld_ok  = bcd_valid(ld_t) && bcd_valid(ld_u)
                && (ld_bin < MOD_BIN);

   assign co = en & ~ld & ~cr & term;

   always_comb begin
      u_d   = u_q;
      t_d   = t_q;
      err_d = 1'b0;
      if (ld) begin
         if (ld_ok) begin
            t_d = ld_t;
            u_d = ld_u;
         end else begin
            err_d = 1'b1;
         end
      end else if (en) begin
         // Wrap beats the digit carry so MOD=100 and MOD=24
         // both return to 00 from their last value.
         if (term) begin
            {t_d, u_d} = dir ? TOP_BCD : 8'h00;
         end else begin
            t_d = t_nx;
            u_d = u_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cr) begin
         t_q   <= INIT_BCD[7:4];
         u_q   <= INIT_BCD[3:0];
         err_q <= 1'b0;
      end else begin
         t_q   <= t_d;
         u_q   <= u_d;
         err_q <= err_d;
      end
   end

   assign bcd_u    = u_q;
   assign bcd_t    = t_q;
   assign load_err = err_q;

endmodule
